// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response encodings, FSM state types and beat-count helper.
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // AxLEN holds the beat count directly; zero is treated as a single beat.
    function automatic logic [3:0] beats(input logic [3:0] len);
        return (len == 4'd0) ? 4'd1 : len;
    endfunction
endpackage

// File: rtl/axi_s_ram_mem.sv
// axi_s_ram_mem: 2^DEPTH_LOG2 x 32 word array, synchronous byte-enabled write, combinational read.
// Ports: clk; we/be/waddr/wdata write port; raddr/rdata read port (returns old data on same-cycle write).
module axi_s_ram_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);
    logic [31:0] mem_q [1 << DEPTH_LOG2];

    always_ff @(posedge clk)
        if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/axi_s_ram.sv
// axi_s_ram: AXI slave with word-organised RAM; independent write and read burst FSMs.
// Ports: S_AXI_ACLK clock, S_AXI_ARESET async active-high reset, AXI AW/W/B/AR/R channels.
// Build option: define AXI_S_RAM_ERR_EN to return SLVERR for start addresses with bits [27:DEPTH_LOG2+2] set.
module axi_s_ram
    import axi_pkg::*;
#(
    parameter int WIDTH_ID   = 1,
    parameter int WIDTH_AD   = 32,
    parameter int WIDTH_DA   = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [WIDTH_ID-1:0]   S_AXI_AWID,
    input  logic [WIDTH_AD-1:0]   S_AXI_AWADDR,
    input  logic [3:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [WIDTH_DA-1:0]   S_AXI_WDATA,
    input  logic [WIDTH_DA/8-1:0] S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [WIDTH_ID-1:0]   S_AXI_ARID,
    input  logic [WIDTH_AD-1:0]   S_AXI_ARADDR,
    input  logic [3:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_RID,
    output logic [WIDTH_DA-1:0]   S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);
    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [WIDTH_ID-1:0]   w_id_q, w_id_d, r_id_q, r_id_d;
    logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d, r_idx_q, r_idx_d;
    logic [3:0]            w_len_q, w_len_d, r_len_q, r_len_d;
    logic [3:0]            w_beat_q, w_beat_d, r_beat_q, r_beat_d;
    logic                  w_fixed_q, w_fixed_d, r_fixed_q, r_fixed_d;
    logic                  w_err_q, w_err_d, r_err_q, r_err_d;
    logic                  aw_err, ar_err, w_last, r_last, mem_we;
    logic [31:0]           mem_rdata;
    logic                  unused_ok;

`ifdef AXI_S_RAM_ERR_EN
    assign aw_err = |S_AXI_AWADDR[27:DEPTH_LOG2+2];
    assign ar_err = |S_AXI_ARADDR[27:DEPTH_LOG2+2];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Size, WLAST and the unused address bits play no part: all accesses are whole words
    // and bursts end on the counted beat.
    assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_WLAST, S_AXI_AWADDR, S_AXI_ARADDR};

    assign w_last = w_beat_q == w_len_q - 4'd1;
    assign r_last = r_beat_q == r_len_q - 4'd1;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: if (S_AXI_AWVALID) begin
                w_state_d = W_DATA;
                w_id_d    = S_AXI_AWID;
                w_idx_d   = S_AXI_AWADDR[DEPTH_LOG2+1:2];
                w_len_d   = beats(S_AXI_AWLEN);
                w_beat_d  = 4'd0;
                w_fixed_d = S_AXI_AWBURST == BURST_FIXED;
                w_err_d   = aw_err;
            end
            W_DATA: if (S_AXI_WVALID) begin
                w_beat_d  = w_beat_q + 4'd1;
                w_idx_d   = w_fixed_q ? w_idx_q : w_idx_q + 1'b1;
                w_state_d = w_last ? W_RESP : W_DATA;
            end
            W_RESP: w_state_d = S_AXI_BREADY ? W_IDLE : W_RESP;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_fixed_d = r_fixed_q;
        r_err_d   = r_err_q;
        case (r_state_q)
            R_IDLE: if (S_AXI_ARVALID) begin
                r_state_d = R_DATA;
                r_id_d    = S_AXI_ARID;
                r_idx_d   = S_AXI_ARADDR[DEPTH_LOG2+1:2];
                r_len_d   = beats(S_AXI_ARLEN);
                r_beat_d  = 4'd0;
                r_fixed_d = S_AXI_ARBURST == BURST_FIXED;
                r_err_d   = ar_err;
            end
            R_DATA: if (S_AXI_RREADY) begin
                r_beat_d  = r_beat_q + 4'd1;
                r_idx_d   = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;
                r_state_d = r_last ? R_IDLE : R_DATA;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
        if (S_AXI_ARESET) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= 4'd1;
            w_beat_q  <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= 4'd1;
            r_beat_q  <= '0;
            r_fixed_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_fixed_q <= r_fixed_d;
            r_err_q   <= r_err_d;
        end

    // An out-of-range write burst still consumes its beats but never touches the array.
    assign mem_we = (w_state_q == W_DATA) && S_AXI_WVALID && !w_err_q;

    axi_s_ram_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (S_AXI_ACLK),
        .we    (mem_we),
        .be    (S_AXI_WSTRB[3:0]),
        .waddr (w_idx_q),
        .wdata (S_AXI_WDATA[31:0]),
        .raddr (r_idx_q),
        .rdata (mem_rdata)
    );

    assign S_AXI_AWREADY = w_state_q == W_IDLE;
    assign S_AXI_WREADY  = w_state_q == W_DATA;
    assign S_AXI_BVALID  = w_state_q == W_RESP;
    assign S_AXI_BRESP   = (S_AXI_BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_BID     = w_id_q;
    assign S_AXI_ARREADY = r_state_q == R_IDLE;
    assign S_AXI_RVALID  = r_state_q == R_DATA;
    assign S_AXI_RLAST   = S_AXI_RVALID && r_last;
    assign S_AXI_RDATA   = r_err_q ? '0 : WIDTH_DA'(mem_rdata);
    assign S_AXI_RRESP   = (S_AXI_RVALID && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RID     = r_id_q;
endmodule

// File: tb/tb_axi_s_ram.sv
// tb_axi_s_ram: randomized self-checking bench for axi_s_ram against a word-array reference model.
module tb_axi_s_ram;
    logic        clk, rst;
    logic        awid, awvalid, awready, wvalid, wready, wlast, bid, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awlen, wstrb, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, arburst, rresp;
    logic        arid, arvalid, arready, rid, rlast, rvalid, rready;

    axi_s_ram dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [1024];
    bit          known [1024];

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [1:0]  w_bresp;
    logic        w_bid;
    bit          w_wready_ok, w_b_next;

    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    int          r_got, r_cycles;
    logic        r_rid;
    bit          r_first_ok, r_hold_ok, r_arr_ok, r_done_ok, r_valid_ok;

    function automatic int nbeats(input logic [3:0] len);
        return (len == 4'd0) ? 1 : int'(len);
    endfunction

    function automatic bit out_of_range(input logic [31:0] addr);
`ifdef AXI_S_RAM_ERR_EN
        return addr[27:12] != 16'd0;
`else
        return addr != addr;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] addr, input logic [1:0] burst, input int i);
        int base;
        base = int'(addr[11:2]);
        return (burst == 2'b00) ? base : (base + i) % 1024;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        int idx;
        if (!out_of_range(addr))
            for (int i = 0; i < nbeats(len); i++) begin
                idx = word_of(addr, burst, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
                if (ws[i] == 4'hF) known[idx] = 1'b1;
            end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                             input logic id, input bit early_last);
        int k;
        int n;
        n = nbeats(len);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        awvalid = 1'b0;
        w_wready_ok = wready;
        for (int i = 0; i < n; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
            wlast = early_last ? (i == 0) : (i == n - 1);
            while (!wready && k < 50) begin @(negedge clk); k++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        w_b_next = bvalid;
        while (!bvalid && k < 50) begin @(negedge clk); k++; end
        w_bresp = bresp; w_bid = bid;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        n_checks++;
        if (k >= 50) begin n_fail++; $display("FAIL write_timeout addr %h got %0d waits limit 50", addr, k); end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic id, input int mode);
        int k;
        int n;
        bit have_prev, rr;
        logic [31:0] pd;
        logic pl;
        n = nbeats(len);
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        arvalid = 1'b0;
        r_first_ok = rvalid; r_rid = rid;
        r_got = 0; r_hold_ok = 1; r_arr_ok = 1; r_valid_ok = 1; have_prev = 0; pd = '0; pl = 1'b0;
        k = 0;
        while (r_got < n && k < 200) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            rready = rr;
            if (!rvalid) r_valid_ok = 0;
            if (arready) r_arr_ok = 0;
            if (have_prev && (rdata !== pd || rlast !== pl)) r_hold_ok = 0;
            if (rvalid && rr) begin
                rd_data[r_got] = rdata; rd_last[r_got] = rlast; rd_resp[r_got] = rresp;
                r_got++;
                have_prev = 0;
            end else begin
                have_prev = rvalid; pd = rdata; pl = rlast;
            end
            k++;
            @(negedge clk);
        end
        rready = 1'b0;
        r_cycles = k;
        r_done_ok = arready && !rvalid;
        n_checks++;
        if (r_got != n) begin n_fail++; $display("FAIL read_beats addr %h got %0d beats exp %0d", addr, r_got, n); end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid} !== 12'hC00) begin
            n_fail++; $display("FAIL reset_outputs got %h exp c00",
                {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid} !== 12'hC00) begin
            n_fail++; $display("FAIL post_reset_outputs got %h exp c00",
                {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid});
        end
    endtask

    task automatic test_fixed;
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(32'h1000_0008, 4'd1, 2'b00, 1'b1, 1'b0);
        model_write(32'h1000_0008, 4'd1, 2'b00);
        n_checks++;
        if ({w_wready_ok, w_b_next} !== 2'b11) begin n_fail++; $display("FAIL fixed_timing got %b exp 11", {w_wready_ok, w_b_next}); end
        n_checks++;
        if ({w_bresp, w_bid} !== 3'b001) begin n_fail++; $display("FAIL fixed_bresp_bid got %b exp 001", {w_bresp, w_bid}); end
        axi_read(32'h1000_0008, 4'd1, 2'b00, 1'b0, 0);
        n_checks++;
        if (rd_data[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fixed_rdata got %h exp deadbeef", rd_data[0]); end
        n_checks++;
        if ({r_first_ok, rd_last[0], rd_resp[0], r_rid, r_cycles == 1} !== 6'b110001) begin
            n_fail++; $display("FAIL fixed_rflags got %b exp 110001", {r_first_ok, rd_last[0], rd_resp[0], r_rid, r_cycles == 1});
        end
    endtask

    task automatic test_incr;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * (i + 1); ws[i] = 4'hF; end
        axi_write(32'h0000_0010, 4'd4, 2'b01, 1'b0, 1'b1);
        model_write(32'h0000_0010, 4'd4, 2'b01);
        n_checks++;
        if ({w_wready_ok, w_b_next, w_bresp} !== 4'b1100) begin n_fail++; $display("FAIL incr_write got %b exp 1100", {w_wready_ok, w_b_next, w_bresp}); end
        axi_read(32'h0000_0010, 4'd4, 2'b01, 1'b1, 0);
        for (int i = 0; i < r_got; i++) begin
            n_checks++;
            if (rd_data[i] !== 32'h11 * (i + 1) || rd_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL incr_beat%0d got %h/%b exp %h/%b", i, rd_data[i], rd_last[i], 32'h11 * (i + 1), i == 3);
            end
        end
        n_checks++;
        if ({r_cycles == 4, r_done_ok, r_arr_ok} !== 3'b111) begin n_fail++; $display("FAIL incr_read_timing got %b exp 111", {r_cycles == 4, r_done_ok, r_arr_ok}); end
    endtask

    task automatic test_strobe;
        wd[0] = 32'h0; ws[0] = 4'hF;
        axi_write(32'h0000_0040, 4'd0, 2'b01, 1'b0, 1'b0);
        model_write(32'h0000_0040, 4'd0, 2'b01);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        axi_write(32'h0000_0041, 4'd1, 2'b01, 1'b0, 1'b0);
        model_write(32'h0000_0041, 4'd1, 2'b01);
        axi_read(32'h0000_0040, 4'd1, 2'b01, 1'b0, 2);
        n_checks++;
        if (rd_data[0] !== 32'h00BB00DD) begin n_fail++; $display("FAIL strobe_rdata got %h exp 00bb00dd", rd_data[0]); end
    endtask

    task automatic test_backpressure;
        axi_read(32'h0000_0010, 4'd4, 2'b01, 1'b1, 1);
        n_checks++;
        if ({r_first_ok, r_valid_ok, r_hold_ok, r_arr_ok, r_done_ok, r_rid} !== 6'b111111) begin
            n_fail++; $display("FAIL bp_flags got %b exp 111111", {r_first_ok, r_valid_ok, r_hold_ok, r_arr_ok, r_done_ok, r_rid});
        end
        for (int i = 0; i < r_got; i++) begin
            n_checks++;
            if (rd_data[i] !== ref_mem[4 + i] || rd_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL bp_beat%0d got %h/%b exp %h/%b", i, rd_data[i], rd_last[i], ref_mem[4 + i], i == 3);
            end
        end
    endtask

    task automatic test_wrap_concurrent;
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            axi_write(32'h0000_0FFC, 4'd4, 2'b01, 1'b1, 1'b0);
            axi_read(32'h0000_0014, 4'd4, 2'b01, 1'b0, 0);
        join
        for (int i = 0; i < r_got; i++) begin
            n_checks++;
            if (rd_data[i] !== ref_mem[5 + i]) begin n_fail++; $display("FAIL conc_read%0d got %h exp %h", i, rd_data[i], ref_mem[5 + i]); end
        end
        model_write(32'h0000_0FFC, 4'd4, 2'b01);
        axi_read(32'h0000_0FFC, 4'd4, 2'b01, 1'b0, 2);
        for (int i = 0; i < r_got; i++) begin
            n_checks++;
            if (rd_data[i] !== wd[i] || ref_mem[word_of(32'h0FFC, 2'b01, i)] !== wd[i]) begin
                n_fail++; $display("FAIL wrap_word%0d got %h exp %h", word_of(32'h0FFC, 2'b01, i), rd_data[i], wd[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        @(negedge clk);
        awid = 1'b1; awaddr = 32'h0000_0190; awlen = 4'd4; awburst = 2'b01; awvalid = 1'b1;
        arid = 1'b1; araddr = 32'h0000_0010; arlen = 4'd4; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
            @(negedge clk);
        end
        wvalid = 1'b0;
        n_checks++;
        if ({wready, rvalid, bid, rid} !== 4'b1111) begin n_fail++; $display("FAIL midrst_busy got %b exp 1111", {wready, rvalid, bid, rid}); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid} !== 12'hC00) begin
            n_fail++; $display("FAIL midrst_outputs got %h exp c00",
                {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid});
        end
        model_write(32'h0000_0190, 4'd2, 2'b01);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        axi_read(32'h0000_0190, 4'd2, 2'b01, 1'b0, 0);
        for (int i = 0; i < r_got; i++) begin
            n_checks++;
            if (rd_data[i] !== ref_mem[100 + i]) begin n_fail++; $display("FAIL midrst_kept%0d got %h exp %h", i, rd_data[i], ref_mem[100 + i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic        id;
        int          idx;
        for (int it = 0; it < 16; it++) begin
            addr = $urandom & 32'h0000_0FFF;
            len = 4'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            id = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end
            axi_write(addr, len, burst, id, 1'($urandom_range(0, 1)));
            model_write(addr, len, burst);
            n_checks++;
            if ({w_bresp, w_bid} !== {2'b00, id}) begin n_fail++; $display("FAIL rnd%0d_b got %b exp %b", it, {w_bresp, w_bid}, {2'b00, id}); end
            axi_read(addr, len, burst, ~id, 2);
            n_checks++;
            if ({r_hold_ok, r_rid} !== {1'b1, ~id}) begin n_fail++; $display("FAIL rnd%0d_hold_rid got %b exp %b", it, {r_hold_ok, r_rid}, {1'b1, ~id}); end
            for (int i = 0; i < r_got; i++) begin
                idx = word_of(addr, burst, i);
                n_checks++;
                if ((known[idx] && rd_data[i] !== ref_mem[idx]) || rd_last[i] !== (i == nbeats(len) - 1) || rd_resp[i] !== 2'b00) begin
                    n_fail++; $display("FAIL rnd%0d_beat%0d got %h/%b/%b exp %h/%b/00", it, i, rd_data[i], rd_last[i], rd_resp[i], ref_mem[idx], i == nbeats(len) - 1);
                end
            end
        end
    endtask

    task automatic test_range;
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
`ifdef AXI_S_RAM_ERR_EN
        axi_write(32'h0800_0000, 4'd2, 2'b01, 1'b0, 1'b0);
        model_write(32'h0800_0000, 4'd2, 2'b01);
        n_checks++;
        if (w_bresp !== 2'b10) begin n_fail++; $display("FAIL err_bresp got %b exp 10", w_bresp); end
        axi_read(32'h0000_0000, 4'd2, 2'b01, 1'b0, 0);
        for (int i = 0; i < r_got; i++) begin
            n_checks++;
            if (rd_data[i] !== ref_mem[i]) begin n_fail++; $display("FAIL err_unchanged%0d got %h exp %h", i, rd_data[i], ref_mem[i]); end
        end
        axi_read(32'h0800_0000, 4'd2, 2'b01, 1'b0, 1);
        for (int i = 0; i < r_got; i++) begin
            n_checks++;
            if ({rd_data[i], rd_resp[i]} !== {32'h0, 2'b10}) begin n_fail++; $display("FAIL err_read%0d got %h/%b exp 0/10", i, rd_data[i], rd_resp[i]); end
        end
`else
        axi_write(32'h0800_0010, 4'd1, 2'b01, 1'b0, 1'b0);
        model_write(32'h0800_0010, 4'd1, 2'b01);
        n_checks++;
        if (w_bresp !== 2'b00) begin n_fail++; $display("FAIL alias_bresp got %b exp 00", w_bresp); end
        axi_read(32'h0000_0010, 4'd1, 2'b01, 1'b0, 0);
        n_checks++;
        if ({rd_data[0], rd_resp[0]} !== {wd[0], 2'b00}) begin n_fail++; $display("FAIL alias_read got %h/%b exp %h/00", rd_data[0], rd_resp[0], wd[0]); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid, bready} = '0;
        {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
        for (int i = 0; i < 1024; i++) begin ref_mem[i] = 'x; known[i] = 1'b0; end
        repeat (3) @(negedge clk);
        test_reset;
        test_fixed;
        test_incr;
        test_strobe;
        test_backpressure;
        test_wrap_concurrent;
        test_reset_mid;
        test_random;
        test_range;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
